// File: rtl/dm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dm_pkg
// Description : Shared constants, state encoding and port-index type for the
//               data-memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package dm_pkg;

    localparam int DM_DEPTH = 3072;
    localparam int DM_AW    = 16;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_SERVE = 1'b1;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_idx_t;

    function automatic port_idx_t other_port(input port_idx_t p);
        return (p == PORT0) ? PORT1 : PORT0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-input round-robin grant; the pointer names the favoured
//               port and flips to the other port after every grant.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
    import dm_pkg::*;
(
    input  logic       clk,
    input  logic       res,
    input  logic       i_en,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    port_idx_t  r_ptr;
    logic [1:0] w_gnt;

    always_comb begin
        w_gnt = 2'b00;
        if (i_en) begin
            if (i_req == 2'b11) begin
                w_gnt = (r_ptr == PORT0) ? 2'b01 : 2'b10;
            end else begin
                w_gnt = i_req;
            end
        end
    end

    assign o_gnt = w_gnt;

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_ptr <= PORT0;
        end else if (|w_gnt) begin
            r_ptr <= other_port(w_gnt[1] ? PORT1 : PORT0);
        end
    end

endmodule
`default_nettype wire

// File: rtl/dm_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dm_arbiter
// Description : Two-requester data-memory arbiter with a full zero-clear sweep
//               after reset or on request, and one-cycle registered responses.
// Revision    : 1.0 - initial release
// ============================================================================
module dm_arbiter
    import dm_pkg::*;
#(
    parameter int DEPTH = DM_DEPTH,
    parameter int AW    = DM_AW
) (
    input  logic          clk,
    input  logic          res,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [31:0]   m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [31:0]   m0_rdata,
    output logic          m0_err,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [31:0]   m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [31:0]   m1_rdata,
    output logic          m1_err,
    input  logic          clr_req,
    output logic          dm_we,
    output logic [AW-1:0] dm_addr,
    output logic [31:0]   dm_wdata,
    input  logic [31:0]   dm_rdata,
    output logic          ready
);

    localparam int            c_CW        = AW - 2;
    localparam logic [c_CW-1:0] c_LAST_WORD = c_CW'(DEPTH - 1);

    logic [0:0]      r_state;
    logic [c_CW-1:0] r_cnt;
    logic [1:0]      r_rvalid;
    logic [1:0]      r_err;
    logic [31:0]     r_rdata0;
    logic [31:0]     r_rdata1;

    logic            w_en;
    logic [1:0]      w_gnt;
    port_idx_t       w_sel;
    logic [AW-1:0]   w_addr;
    logic [31:0]     w_wdata;
    logic            w_we;
    logic            w_legal;
    logic [31:0]     w_resp_data;

    // Arbitration is suppressed during the sweep and in the cycle a clear is taken.
    assign w_en = (r_state == ST_SERVE) && !clr_req;

    rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .res   (res),
        .i_en  (w_en),
        .i_req ({m1_req, m0_req}),
        .o_gnt (w_gnt)
    );

    always_comb begin
        w_sel       = w_gnt[1] ? PORT1 : PORT0;
        w_addr      = (w_sel == PORT1) ? m1_addr  : m0_addr;
        w_wdata     = (w_sel == PORT1) ? m1_wdata : m0_wdata;
        w_we        = (w_sel == PORT1) ? m1_we    : m0_we;
        w_legal     = (w_addr[1:0] == 2'b00) && (w_addr[AW-1:2] <= c_LAST_WORD);
        w_resp_data = (w_we || !w_legal) ? 32'h0 : dm_rdata;
    end

    always_comb begin
        dm_we    = 1'b0;
        dm_addr  = '0;
        dm_wdata = 32'h0;
        if (r_state == ST_CLEAR) begin
            dm_we   = 1'b1;
            dm_addr = {r_cnt, 2'b00};
        end else if (|w_gnt) begin
            dm_we    = w_we && w_legal;
            dm_addr  = w_addr;
            dm_wdata = w_wdata;
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
        end else if (r_state == ST_CLEAR) begin
            if (r_cnt == c_LAST_WORD) begin
                r_state <= ST_SERVE;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else if (clr_req) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
        end
    end

    // Responses come only from grants, so a response already in flight when a
    // clear is accepted still drains in the following cycle.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_rvalid <= 2'b00;
            r_err    <= 2'b00;
            r_rdata0 <= 32'h0;
            r_rdata1 <= 32'h0;
        end else begin
            r_rvalid <= w_gnt;
            r_err    <= w_gnt & {2{~w_legal}};
            if (w_gnt[0]) begin
                r_rdata0 <= w_resp_data;
            end
            if (w_gnt[1]) begin
                r_rdata1 <= w_resp_data;
            end
        end
    end

    assign m0_gnt    = w_gnt[0];
    assign m1_gnt    = w_gnt[1];
    assign m0_rvalid = r_rvalid[0];
    assign m1_rvalid = r_rvalid[1];
    assign m0_err    = r_err[0];
    assign m1_err    = r_err[1];
    assign m0_rdata  = r_rdata0;
    assign m1_rdata  = r_rdata1;
    assign ready     = (r_state == ST_SERVE);

endmodule
`default_nettype wire

// File: tb/tb_dm_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dm_arbiter
// Description : Self-checking bench for dm_arbiter with a behavioural model,
//               directed scenarios and a randomized request phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_arbiter;

    localparam int DEPTH = 3072;
    localparam int AW    = 16;

    logic          clk = 1'b0;
    logic          res = 1'b0;
    logic          m0_req, m0_we, m1_req, m1_we, clr_req;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [31:0]   m0_wdata, m1_wdata;
    logic          m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [31:0]   m0_rdata, m1_rdata;
    logic          dm_we, ready;
    logic [AW-1:0] dm_addr;
    logic [31:0]   dm_wdata, dm_rdata;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dm_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk      (clk),      .res      (res),
        .m0_req   (m0_req),   .m0_we    (m0_we),    .m0_addr (m0_addr),  .m0_wdata (m0_wdata),
        .m0_gnt   (m0_gnt),   .m0_rvalid(m0_rvalid),.m0_rdata(m0_rdata), .m0_err   (m0_err),
        .m1_req   (m1_req),   .m1_we    (m1_we),    .m1_addr (m1_addr),  .m1_wdata (m1_wdata),
        .m1_gnt   (m1_gnt),   .m1_rvalid(m1_rvalid),.m1_rdata(m1_rdata), .m1_err   (m1_err),
        .clr_req  (clr_req),
        .dm_we    (dm_we),    .dm_addr  (dm_addr),  .dm_wdata(dm_wdata), .dm_rdata (dm_rdata),
        .ready    (ready)
    );

    // The data memory the arbiter drives.
    logic [31:0] dm_mem [DEPTH];
    always @(posedge clk) begin
        if (res && dm_we && (int'(dm_addr[AW-1:2]) < DEPTH)) begin
            dm_mem[dm_addr[AW-1:2]] <= dm_wdata;
        end
    end
    assign dm_rdata = (int'(dm_addr[AW-1:2]) < DEPTH) ? dm_mem[dm_addr[AW-1:2]] : 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at time %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: sweep index, round-robin favourite, expected memory and
    // the single response owed for the next cycle.
    bit          m_clear = 1'b1;
    int          m_idx   = 0;
    int          m_ptr   = 0;
    bit          p_valid = 1'b0;
    int          p_port  = 0;
    bit          p_err   = 1'b0;
    logic [31:0] p_data  = 32'h0;
    logic [31:0] m_mem [DEPTH];

    always @(negedge clk) begin
        bit          exp_ready, e_we, n_valid, n_err, legal, we;
        bit   [1:0]  e_gnt, req;
        logic [AW-1:0] e_addr, a;
        logic [31:0] e_wd, n_data, wd;
        int          win, n_port, wi;
        if (!res) begin
            chk("rst_gnt",    32'({m1_gnt, m0_gnt}), 32'h0);
            chk("rst_dm_we",  32'(dm_we), 32'h1);
            chk("rst_dm_addr",32'(dm_addr), 32'h0);
            chk("rst_wdata",  dm_wdata, 32'h0);
            chk("rst_ready",  32'(ready), 32'h0);
            chk("rst_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'h0);
            m_clear = 1'b1; m_idx = 0; m_ptr = 0; p_valid = 1'b0;
        end else begin
            exp_ready = !m_clear;
            e_gnt = 2'b00; e_we = 1'b0; e_addr = '0; e_wd = 32'h0;
            n_valid = 1'b0; n_port = 0; n_err = 1'b0; n_data = 32'h0;
            if (m_clear) begin
                e_we   = 1'b1;
                e_addr = AW'(m_idx * 4);
                m_mem[m_idx] = 32'h0;
                if (m_idx == DEPTH - 1) begin
                    m_clear = 1'b0; m_idx = 0;
                end else begin
                    m_idx++;
                end
            end else if (clr_req) begin
                m_clear = 1'b1; m_idx = 0;
            end else begin
                req = {m1_req, m0_req};
                win = -1;
                if (req == 2'b11)  win = m_ptr;
                else if (req[0])   win = 0;
                else if (req[1])   win = 1;
                if (win >= 0) begin
                    a  = (win == 1) ? m1_addr  : m0_addr;
                    we = (win == 1) ? m1_we    : m0_we;
                    wd = (win == 1) ? m1_wdata : m0_wdata;
                    wi = int'(a) / 4;
                    legal = (int'(a) % 4 == 0) && (wi < DEPTH);
                    e_gnt[win] = 1'b1;
                    e_addr = a; e_wd = wd; e_we = we && legal;
                    n_valid = 1'b1; n_port = win; n_err = !legal;
                    n_data = (legal && !we) ? m_mem[wi] : 32'h0;
                    if (legal && we) m_mem[wi] = wd;
                    m_ptr = 1 - win;
                end
            end
            chk("ready",    32'(ready), 32'(exp_ready));
            chk("gnt",      32'({m1_gnt, m0_gnt}), 32'(e_gnt));
            chk("dm_we",    32'(dm_we), 32'(e_we));
            chk("dm_addr",  32'(dm_addr), 32'(e_addr));
            chk("dm_wdata", dm_wdata, e_wd);
            chk("rvalid",   32'({m1_rvalid, m0_rvalid}),
                p_valid ? ((p_port == 1) ? 32'h2 : 32'h1) : 32'h0);
            if (p_valid) begin
                chk("rdata", (p_port == 1) ? m1_rdata : m0_rdata, p_data);
                chk("err",   32'((p_port == 1) ? m1_err : m0_err), 32'(p_err));
            end
            p_valid = n_valid; p_port = n_port; p_err = n_err; p_data = n_data;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = 32'h0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = 32'h0;
        clr_req = 1'b0;
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        int r;
        r = int'($urandom_range(0, 15));
        if (r == 0)      return AW'($urandom);
        else if (r == 1) return AW'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
        else if (r == 2) return ($urandom_range(0, 1) == 0) ? 16'h2FFC : 16'h3000;
        else             return AW'($urandom_range(0, 63) * 4);
    endfunction

    task automatic sweep_and_check(input string tag);
        repeat (DEPTH - 1) cyc();
        #1;
        chk({tag, "_last_busy"}, 32'(ready), 32'h0);
        chk({tag, "_last_addr"}, 32'(dm_addr), 32'h2FFC);
        cyc();
        #1;
        chk({tag, "_ready"}, 32'(ready), 32'h1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) dm_mem[i] = $urandom;
        idle();
        res = 1'b0;
        repeat (3) cyc();
        #1;
        chk("reset_ready", 32'(ready), 32'h0);
        chk("reset_dm_we", 32'(dm_we), 32'h1);
        cyc();
        res = 1'b1;
        sweep_and_check("init_sweep");

        // Write then read back through the other port.
        cyc();
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 16'h0010; m0_wdata = 32'hDEADBEEF;
        #1 chk("wr_gnt", 32'(m0_gnt), 32'h1);
        cyc();
        idle(); m1_req = 1'b1; m1_addr = 16'h0010;
        #1;
        chk("wr_ack", 32'(m0_rvalid), 32'h1);
        chk("rd_gnt", 32'(m1_gnt), 32'h1);
        cyc();
        idle();
        #1;
        chk("rd_rvalid", 32'(m1_rvalid), 32'h1);
        chk("rd_data",   m1_rdata, 32'hDEADBEEF);
        chk("rd_err",    32'(m1_err), 32'h0);

        // Both ports held: strict alternation starting at port 0.
        cyc();
        m0_req = 1'b1; m0_addr = 16'h0010; m1_req = 1'b1; m1_addr = 16'h0024;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_gnt", 32'({m1_gnt, m0_gnt}), (i % 2 == 0) ? 32'h1 : 32'h2);
            if (i > 0) chk("rr_rvalid", 32'({m1_rvalid, m0_rvalid}), (i % 2 == 0) ? 32'h2 : 32'h1);
            cyc();
        end
        idle();

        // Illegal accesses: out of range, then misaligned write.
        cyc();
        m1_req = 1'b1; m1_addr = 16'h3000;
        #1;
        chk("ill_rd_gnt", 32'(m1_gnt), 32'h1);
        chk("ill_rd_we",  32'(dm_we), 32'h0);
        cyc();
        idle(); m0_req = 1'b1; m0_we = 1'b1; m0_addr = 16'h0006; m0_wdata = 32'h12345678;
        #1;
        chk("ill_rd_err",   32'(m1_err), 32'h1);
        chk("ill_rd_rdata", m1_rdata, 32'h0);
        chk("ill_wr_we",    32'(dm_we), 32'h0);
        cyc();
        idle();
        #1;
        chk("ill_wr_err",   32'(m0_err), 32'h1);
        chk("ill_wr_rdata", m0_rdata, 32'h0);

        for (int i = 0; i < 2000; i++) begin
            cyc();
            m0_req = ($urandom_range(0, 3) != 0); m0_we = 1'($urandom_range(0, 1));
            m0_addr = rnd_addr(); m0_wdata = $urandom;
            m1_req = ($urandom_range(0, 3) != 0); m1_we = 1'($urandom_range(0, 1));
            m1_addr = rnd_addr(); m1_wdata = $urandom;
        end

        // Clear taken in the middle of a read stream on port 0.
        cyc();
        idle(); m0_req = 1'b1; m0_addr = 16'h0010;
        cyc();
        m0_addr = 16'h0014;
        cyc();
        clr_req = 1'b1;
        #1;
        chk("clr_no_gnt",  32'(m0_gnt), 32'h0);
        chk("clr_pending", 32'(m0_rvalid), 32'h1);
        cyc();
        clr_req = 1'b0;
        #1 chk("clr_busy", 32'(ready), 32'h0);
        sweep_and_check("clr_sweep");
        m0_addr = 16'h0010;
        cyc();
        #1;
        chk("post_clr_rvalid", 32'(m0_rvalid), 32'h1);
        chk("post_clr_rdata",  m0_rdata, 32'h0);
        idle();

        // Reset in the middle of a sweep.
        cyc();
        clr_req = 1'b1;
        cyc();
        clr_req = 1'b0;
        repeat (100) cyc();
        #1 chk("pre_rst_addr", 32'(dm_addr), 32'h0190);
        res = 1'b0;
        #1;
        chk("mid_rst_addr",  32'(dm_addr), 32'h0);
        chk("mid_rst_we",    32'(dm_we), 32'h1);
        chk("mid_rst_ready", 32'(ready), 32'h0);
        repeat (2) cyc();
        res = 1'b1;
        sweep_and_check("rst_sweep");

        repeat (3) cyc();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
